// File: rtl/ca_state_serializer.sv
// Streams an N-bit CA generation snapshot out as N/W beats of W bits, LSB chunk first.
// Optional CA_POPCOUNT_EN: appends a trailing beat carrying the live-cell count of the frame.
module ca_state_serializer #(
  parameter int N = 512,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int BEATS = N / W;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

`ifdef CA_POPCOUNT_EN
  typedef enum logic [1:0] {IDLE, SEND, POP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t        state_reg, state_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic [CW-1:0] cnt_reg, cnt_next;

`ifdef CA_POPCOUNT_EN
  logic [W-1:0]  acc_reg, acc_next;

  function automatic logic [W-1:0] popcount(input logic [W-1:0] v);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + W'(v[i]);
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
`ifdef CA_POPCOUNT_EN
      acc_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
`ifdef CA_POPCOUNT_EN
      acc_reg   <= acc_next;
`endif
    end
  end

  // Outputs decode from the registered state only, so reset clears them asynchronously.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
`ifdef CA_POPCOUNT_EN
    acc_next   = acc_reg;
`endif
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_next = in_data;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = shift_reg[W-1:0];
`ifndef CA_POPCOUNT_EN
        out_last  = (cnt_reg == LAST_BEAT);
`endif
        if (out_ready) begin
          shift_next = shift_reg >> W;
          cnt_next   = cnt_reg + 1'b1;
`ifdef CA_POPCOUNT_EN
          acc_next   = acc_reg + popcount(shift_reg[W-1:0]);
          if (cnt_reg == LAST_BEAT) state_next = POP;
`else
          if (cnt_reg == LAST_BEAT) state_next = IDLE;
`endif
        end
      end
`ifdef CA_POPCOUNT_EN
      POP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = acc_reg;
        out_last  = 1'b1;
        if (out_ready) begin
          acc_next   = '0;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ca_state_serializer.sv
// Directed self-checking bench for ca_state_serializer (default N=512, W=32).
module tb_ca_state_serializer;

  localparam int N  = 512;
  localparam int W  = 32;
  localparam int NB = N / W;
`ifdef CA_POPCOUNT_EN
  localparam int BEATS = NB + 1;
`else
  localparam int BEATS = NB;
`endif

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ca_state_serializer #(.N(N), .W(W)) dut (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_snap(input logic [N-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    chk("in_ready_wait", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_frame(input logic [N-1:0] d, input int stall_beat, input int stall_len);
    logic [W-1:0] exp_w;
    logic         exp_l;
    for (int k = 0; k < BEATS; k++) begin
      for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
      exp_w = (k < NB) ? d[k*W +: W] : W'($countones(d));
      exp_l = (k == BEATS - 1);
      chk($sformatf("beat%0d_valid", k), W'(out_valid), W'(1));
      chk($sformatf("beat%0d_data", k), out_data, exp_w);
      chk($sformatf("beat%0d_last", k), W'(out_last), W'(exp_l));
      chk($sformatf("beat%0d_in_ready", k), W'(in_ready), W'(0));
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_data", s), out_data, exp_w);
          chk($sformatf("stall%0d_last", s), W'(out_last), W'(exp_l));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("post_out_valid", W'(out_valid), W'(0));
    chk("post_in_ready", W'(in_ready), W'(1));
  endtask

  function automatic logic [N-1:0] chunks(input logic [W-1:0] base);
    logic [N-1:0] v;
    for (int k = 0; k < NB; k++) v[k*W +: W] = base + W'(k);
    return v;
  endfunction

  initial begin
    logic [N-1:0] d;
    int beats_seen;
    int idle_seen;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_out_data", out_data, W'(0));
    areset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", W'(in_ready), W'(1));

    // 1: single live cell
    d = '0;
    d[0] = 1'b1;
    send_snap(d);
    chk("t1_busy", W'(busy), W'(1));
    recv_frame(d, -1, 0);

    // 2: chunk k = k, stall 3 cycles on beat 5
    send_snap(chunks(W'(0)));
    recv_frame(chunks(W'(0)), 5, 3);

    // 3: second snapshot offered during SEND is held off until IDLE
    send_snap(chunks(W'(32'h100)));
    in_data  = chunks(W'(32'h200));
    in_valid = 1'b1;
    recv_frame(chunks(W'(32'h100)), -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    recv_frame(chunks(W'(32'h200)), -1, 0);

    // 4: asynchronous reset mid-frame at beat 7
    send_snap(chunks(W'(32'hA0)));
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t4_beat%0d", k), out_data, W'(32'hA0 + k));
      @(negedge clk);
    end
    chk("t4_beat7", out_data, W'(32'hA7));
    areset_n = 1'b0;
    #1;
    chk("t4_rst_valid", W'(out_valid), W'(0));
    chk("t4_rst_busy", W'(busy), W'(0));
    chk("t4_rst_last", W'(out_last), W'(0));
    chk("t4_rst_data", out_data, W'(0));
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    chk("t4_in_ready", W'(in_ready), W'(1));
    chk("t4_out_valid", W'(out_valid), W'(0));
    send_snap(chunks(W'(32'hC0)));
    recv_frame(chunks(W'(32'hC0)), -1, 0);

    // 5: all ones then all zeros (count beat present only with CA_POPCOUNT_EN)
    send_snap({N{1'b1}});
    recv_frame({N{1'b1}}, -1, 0);
    send_snap('0);
    recv_frame('0, -1, 0);

    // 6: in_valid held high across two frames with out_ready high
    beats_seen = 0;
    idle_seen  = 0;
    in_data  = chunks(W'(32'h300));
    in_valid = 1'b1;
    for (int c = 0; c < 2 * (BEATS + 1); c++) begin
      if (out_valid) beats_seen++;
      else idle_seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t6_beats", W'(beats_seen), W'(2 * BEATS));
    chk("t6_idle", W'(idle_seen), W'(2));
    chk("t6_end_in_ready", W'(in_ready), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca_state_serializer.md
Name: ca_state_serializer

Overview:
- Reader side of the 512-cell cellular-automaton state register.
- Captures one full N-bit generation snapshot over a valid/ready handshake and streams it out as N/W beats of W bits, LSB chunk first.
- Feeds the narrow debug/trace path so each generation can be dumped without widening the bus.
- One frame in flight at a time; output is fully backpressure-tolerant.

Parameters:
- N, 512, number of cells in one snapshot; must be a multiple of W.
- W, 32, output beat width in bits; must be >= clog2(N+1).

Ports:
- clk  input  1  rising-edge clock
- areset_n  input  1  asynchronous active-low reset
- in_valid  input  1  snapshot offered
- in_ready  output  1  block can accept a snapshot
- in_data  input  N  snapshot; bit i = cell i
- out_valid  output  1  beat valid
- out_ready  input  1  sink accepts beat
- out_data  output  W  beat payload
- out_last  output  1  final beat of frame
- busy  output  1  frame capture/streaming in progress

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; reset areset_n is asynchronous, active-low. Assertion forces state IDLE, shift register 0, beat counter 0, out_valid 0, out_last 0, out_data 0, busy 0, and any popcount accumulator 0. in_ready is 1 once reset is released.
- Reset mid-frame: the partial frame is discarded. Streaming never resumes; the next frame starts at beat 0.
- States: IDLE, SEND (plus POP when CA_POPCOUNT_EN is defined).
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&in_ready: latch in_data into the shift register, clear the beat counter, go to SEND next cycle.
- SEND:
  - in_ready=0, busy=1, out_valid=1, out_data = shift_reg[W-1:0].
  - Beat k carries cells k*W .. k*W+W-1.
  - On out_valid&out_ready: shift the register right by W and increment the counter.
  - When counter == N/W-1, the beat drives out_last=1. Its handshake returns the block to IDLE (or POP).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the counter hold stable.
- in_valid during SEND/POP is ignored; the source must hold it until in_ready.
- Latency: first beat is valid the cycle after the input handshake. With out_ready tied high a frame takes N/W cycles plus 1 idle cycle before the next capture, so back-to-back throughput is one frame per N/W+1 cycles.
- out_last is asserted only together with out_valid.

Optional Feature:
- Macro: CA_POPCOUNT_EN.
- Defined:
  - A W-bit accumulator adds popcount(shift_reg[W-1:0]) on each SEND beat handshake.
  - After the last data beat, go to POP and emit one extra beat: out_data = live-cell count zero-extended to W.
  - out_last moves to this POP beat (data beats all carry out_last=0).
  - The POP handshake returns to IDLE and clears the accumulator.
  - The frame is N/W+1 beats.
- Undefined: no accumulator, no POP state. The frame is N/W beats with out_last on the final data beat.

Test Plan:
1. Reset, then load in_data with only bit 0 set, out_ready=1 -> 16 beats; beat 0 out_data=32'h00000001, beats 1-15 = 0; out_last only on beat 15; in_ready=1 the cycle after.
2. Load in_data chunk k = k (k=0..15); drop out_ready for 3 cycles at beat 5 -> out_data holds 32'h5 for all 3 cycles, then beats 5..15 continue with no skips or duplicates.
3. Offer a second snapshot with in_valid=1 during SEND -> in_ready=0 and nothing is captured; it is accepted in IDLE after out_last, and its beat 0 matches the new data.
4. Drop areset_n at beat 7 -> out_valid, busy, out_last = 0 immediately (asynchronous); after release in_ready=1, and the next frame starts at beat 0 with the new data.
5. With CA_POPCOUNT_EN defined, load all ones -> 16 beats of 32'hFFFFFFFF with out_last=0, then beat 16 out_data=32'd512 with out_last=1. Next frame, all zeros -> count beat = 0.
6. Two frames with in_valid held high and out_ready=1 -> exactly one idle cycle between frames; total beat count is 32 (34 with CA_POPCOUNT_EN).
